// File: rtl/core_step_ctrl_if.sv
// Handshake and control bundle between the step sequencer, IFU, LSU, decoder and commit logic.
// master = sequencer side, slave = surrounding core side.
interface core_step_ctrl_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic                 ifu_req;
  logic                 ifu_rvalid;
  logic                 inst_valid;
  logic                 dec_mem_ren;
  logic                 dec_mem_wen;
  logic                 dec_r_wen;
  logic                 dec_csr_wen;
  logic                 dec_halt;
  logic                 lsu_req;
  logic                 lsu_wen;
  logic                 lsu_done;
  logic                 pc_wen;
  logic                 rf_wen;
  logic                 csr_commit;
  logic                 halted;
  logic                 timeout;
  logic [INSTRET_W-1:0] instret;

  modport master (
    output ifu_req, inst_valid, lsu_req, lsu_wen, pc_wen, rf_wen, csr_commit,
           halted, timeout, instret,
    input  ifu_rvalid, dec_mem_ren, dec_mem_wen, dec_r_wen, dec_csr_wen, dec_halt,
           lsu_done
  );

  modport slave (
    input  ifu_req, inst_valid, lsu_req, lsu_wen, pc_wen, rf_wen, csr_commit,
           halted, timeout, instret,
    output ifu_rvalid, dec_mem_ren, dec_mem_wen, dec_r_wen, dec_csr_wen, dec_halt,
           lsu_done
  );
endinterface

// File: rtl/core_step_ctrl.sv
// Multi-cycle step sequencer: FETCH -> EXEC -> (MEM) -> WB with one commit per instruction,
// EBREAK halt and FETCH/MEM wait timeout. All outputs are registered.
module core_step_ctrl #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned INSTRET_W = 32
) (
  input logic               clk,
  input logic               rst,
  core_step_ctrl_if.master  bus_io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  // Last wait count that may still complete; one more idle cycle is a timeout.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  state_e               state_q;
  logic [TIMEOUT_W-1:0] wait_q;
  logic                 r_q;
  logic                 csr_q;
  logic                 ifu_req_q;
  logic                 inst_valid_q;
  logic                 lsu_req_q;
  logic                 lsu_wen_q;
  logic                 pc_wen_q;
  logic                 rf_wen_q;
  logic                 csr_commit_q;
  logic                 halted_q;
  logic                 timeout_q;
  logic [INSTRET_W-1:0] instret_q;

  logic r_d;
  logic mem_d;

  // A load+store decode is treated as a store, so it never writes rd.
  assign r_d   = bus_io.dec_r_wen & ~(bus_io.dec_mem_ren & bus_io.dec_mem_wen);
  assign mem_d = bus_io.dec_mem_ren | bus_io.dec_mem_wen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      r_q          <= 1'b0;
      csr_q        <= 1'b0;
      ifu_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      lsu_req_q    <= 1'b0;
      lsu_wen_q    <= 1'b0;
      pc_wen_q     <= 1'b0;
      rf_wen_q     <= 1'b0;
      csr_commit_q <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      instret_q    <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      pc_wen_q     <= 1'b0;
      rf_wen_q     <= 1'b0;
      csr_commit_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          state_q   <= S_FETCH;
          ifu_req_q <= 1'b1;
          wait_q    <= '0;
        end
        S_FETCH: begin
          if (bus_io.ifu_rvalid) begin
            state_q      <= S_EXEC;
            ifu_req_q    <= 1'b0;
            inst_valid_q <= 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= S_HALT;
            ifu_req_q <= 1'b0;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TIMEOUT_W'(1);
          end
        end
        S_EXEC: begin
          r_q   <= r_d;
          csr_q <= bus_io.dec_csr_wen;
          if (bus_io.dec_halt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (mem_d) begin
            state_q   <= S_MEM;
            lsu_req_q <= 1'b1;
            lsu_wen_q <= bus_io.dec_mem_wen;
            wait_q    <= '0;
          end else begin
            state_q      <= S_WB;
            pc_wen_q     <= 1'b1;
            rf_wen_q     <= r_d;
            csr_commit_q <= bus_io.dec_csr_wen;
          end
        end
        S_MEM: begin
          if (bus_io.lsu_done) begin
            state_q      <= S_WB;
            lsu_req_q    <= 1'b0;
            lsu_wen_q    <= 1'b0;
            pc_wen_q     <= 1'b1;
            rf_wen_q     <= r_q;
            csr_commit_q <= csr_q;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= S_HALT;
            lsu_req_q <= 1'b0;
            lsu_wen_q <= 1'b0;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TIMEOUT_W'(1);
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          ifu_req_q <= 1'b1;
          wait_q    <= '0;
          instret_q <= instret_q + INSTRET_W'(1);
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_io.ifu_req    = ifu_req_q;
  assign bus_io.inst_valid = inst_valid_q;
  assign bus_io.lsu_req    = lsu_req_q;
  assign bus_io.lsu_wen    = lsu_wen_q;
  assign bus_io.pc_wen     = pc_wen_q;
  assign bus_io.rf_wen     = rf_wen_q;
  assign bus_io.csr_commit = csr_commit_q;
  assign bus_io.halted     = halted_q;
  assign bus_io.timeout    = timeout_q;
  assign bus_io.instret    = instret_q;

endmodule

// File: tb/tb_core_step_ctrl.sv
// Directed bench for core_step_ctrl: per-cycle vector table plus hand sequences for
// timeout, completion on the last legal wait cycle and reset in the middle of MEM.
module tb_core_step_ctrl;

  // in  = {rst, ifu_rvalid, ren, wen, r_wen, csr_wen, halt, lsu_done}
  // exp = {ifu_req, inst_valid, lsu_req, lsu_wen, pc_wen, rf_wen, csr_commit, halted, timeout}
  typedef struct packed {
    logic [7:0]  in;
    logic [8:0]  exp;
    logic [31:0] ir;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  core_step_ctrl_if #(.INSTRET_W(32)) bus ();

  core_step_ctrl #(.TIMEOUT_W(4), .INSTRET_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] in);
    rst             = in[7];
    bus.ifu_rvalid  = in[6];
    bus.dec_mem_ren = in[5];
    bus.dec_mem_wen = in[4];
    bus.dec_r_wen   = in[3];
    bus.dec_csr_wen = in[2];
    bus.dec_halt    = in[1];
    bus.lsu_done    = in[0];
  endtask

  function automatic logic [8:0] outs();
    return {bus.ifu_req, bus.inst_valid, bus.lsu_req, bus.lsu_wen, bus.pc_wen,
            bus.rf_wen, bus.csr_commit, bus.halted, bus.timeout};
  endfunction

  task automatic check(input string name, input logic [8:0] e, input logic [31:0] ir);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", name, outs(), e);
    end
    checks++;
    if (bus.instret !== ir) begin
      errors++;
      $display("FAIL %s instret got %0d want %0d", name, bus.instret, ir);
    end
  endtask

  task automatic cyc(input logic [7:0] in);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(8'b1000_0000);

    // reset, release
    vq.push_back('{8'b1000_0000, 9'b000000000, 32'd0});
    vq.push_back('{8'b1000_0000, 9'b000000000, 32'd0});
    vq.push_back('{8'b1000_0000, 9'b000000000, 32'd0});
    vq.push_back('{8'b0000_0000, 9'b100000000, 32'd0});
    // ALU op writing rd
    vq.push_back('{8'b0100_1000, 9'b010000000, 32'd0});
    vq.push_back('{8'b0000_1000, 9'b000011000, 32'd0});
    vq.push_back('{8'b0000_0000, 9'b100000000, 32'd1});
    // load, lsu_done in third MEM cycle
    vq.push_back('{8'b0100_0000, 9'b010000000, 32'd1});
    vq.push_back('{8'b0010_1000, 9'b001000000, 32'd1});
    vq.push_back('{8'b0000_0000, 9'b001000000, 32'd1});
    vq.push_back('{8'b0000_0000, 9'b001000000, 32'd1});
    vq.push_back('{8'b0000_0001, 9'b000011000, 32'd1});
    vq.push_back('{8'b0000_0000, 9'b100000000, 32'd2});
    // ren+wen+r_wen behaves as a store without rd write
    vq.push_back('{8'b0100_0000, 9'b010000000, 32'd2});
    vq.push_back('{8'b0011_1000, 9'b001100000, 32'd2});
    vq.push_back('{8'b0000_0001, 9'b000010000, 32'd2});
    vq.push_back('{8'b0000_0000, 9'b100000000, 32'd3});
    // CSR op
    vq.push_back('{8'b0100_0000, 9'b010000000, 32'd3});
    vq.push_back('{8'b0000_0100, 9'b000010100, 32'd3});
    vq.push_back('{8'b0000_0001, 9'b100000000, 32'd4});
    vq.push_back('{8'b0000_0001, 9'b100000000, 32'd4});
    // EBREAK, then stray completions are ignored
    vq.push_back('{8'b0100_0000, 9'b010000000, 32'd4});
    vq.push_back('{8'b0000_1010, 9'b000000010, 32'd4});
    vq.push_back('{8'b0100_0000, 9'b000000010, 32'd4});
    vq.push_back('{8'b0100_0001, 9'b000000010, 32'd4});

    foreach (vq[i]) begin
      cyc(vq[i].in);
      check($sformatf("vec%0d", i), vq[i].exp, vq[i].ir);
    end

    // FETCH timeout after 15 waiting cycles
    cyc(8'b1000_0000);
    cyc(8'b0000_0000);
    for (int i = 0; i < 14; i++) cyc(8'b0000_0000);
    check("fetch_wait14", 9'b100000000, 32'd0);
    cyc(8'b0000_0000);
    check("fetch_timeout", 9'b000000011, 32'd0);
    cyc(8'b0100_0001);
    check("timeout_sticky", 9'b000000011, 32'd0);

    // completion on the last legal wait cycle is accepted
    cyc(8'b1000_0000);
    cyc(8'b0000_0000);
    for (int i = 0; i < 14; i++) cyc(8'b0000_0000);
    cyc(8'b0100_0000);
    check("fetch_last_cycle", 9'b010000000, 32'd0);

    // MEM timeout: store never completes
    cyc(8'b0001_0000);
    check("mem_enter", 9'b001100000, 32'd0);
    for (int i = 0; i < 14; i++) cyc(8'b0000_0000);
    check("mem_wait14", 9'b001100000, 32'd0);
    cyc(8'b0000_0000);
    check("mem_timeout", 9'b000000011, 32'd0);

    // reset in the middle of MEM
    cyc(8'b1000_0000);
    cyc(8'b0000_0000);
    cyc(8'b0100_0000);
    cyc(8'b0000_1000);
    cyc(8'b0000_0000);
    check("pre_mem_fetch", 9'b100000000, 32'd1);
    cyc(8'b0100_0000);
    cyc(8'b0010_1000);
    check("mid_mem", 9'b001000000, 32'd1);
    #2;
    drive(8'b1000_0001);
    #1;
    check("async_rst", 9'b000000000, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held", 9'b000000000, 32'd0);
    cyc(8'b0000_0001);
    check("rst_release", 9'b100000000, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
